// File: rtl/nwd_ctrl.sv
// nwd_ctrl: initiator for a start/finish subtractive GCD core.
// Takes operand pairs on a valid/ready request port and pulses core_ini to
// load the core. It then counts RUN cycles until core_fin or the watchdog
// limit, and returns the result on a valid/ready response port. When either
// operand is zero the answer is known at once, so the core is skipped.
module nwd_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned TIMEOUT = 70000
) (
  input  logic             clk,
  input  logic             rst,
  // request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_s,
  output logic             rsp_err,
  output logic [CNT_W-1:0] rsp_cycles,
  // GCD core side
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  output logic             core_ini,
  input  logic [W-1:0]     core_s,
  input  logic             core_fin
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     core_a_q, core_a_d;
  logic [W-1:0]     core_b_q, core_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rsp_s_q, rsp_s_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;

  logic a_zero, b_zero;
  assign a_zero = (req_a == '0);
  assign b_zero = (req_b == '0);

  // Next-state, datapath updates and state-decoded strobes.
  always_comb begin
    state_d      = state_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    cnt_d        = cnt_q;
    rsp_s_d      = rsp_s_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    core_ini     = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          core_a_d = req_a;
          core_b_d = req_b;
          if (!a_zero && !b_zero) begin
            state_d = StLoad;
          end else begin
            // With one zero operand the GCD is the other operand. With
            // both zero the GCD is undefined, so the error flag is set.
            state_d      = StResp;
            rsp_s_d      = a_zero ? req_b : req_a;
            rsp_err_d    = a_zero && b_zero;
            rsp_cycles_d = '0;
          end
        end
      end

      StLoad: begin
        // core_fin still reflects the previous operands here, so it is ignored.
        core_ini = 1'b1;
        cnt_d    = CntOne;
        state_d  = StRun;
      end

      StRun: begin
        if (core_fin) begin
          rsp_s_d      = core_s;
          rsp_err_d    = 1'b0;
          rsp_cycles_d = cnt_q;
          state_d      = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          rsp_s_d      = '0;
          rsp_err_d    = 1'b1;
          rsp_cycles_d = TimeoutCnt;
          state_d      = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      core_a_q     <= '0;
      core_b_q     <= '0;
      cnt_q        <= '0;
      rsp_s_q      <= '0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      cnt_q        <= cnt_d;
      rsp_s_q      <= rsp_s_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_nwd_ctrl.sv
// Testbench for nwd_ctrl: a behavioural subtractive GCD core is attached to the
// main instance. A second instance with a short watchdog has core_fin tied low.
module tb_nwd_ctrl;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned TO_SH = 8;
  localparam int          LIMIT = 80000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]     req_a, req_b, rsp_s, core_a, core_b, core_s;
  logic [CNT_W-1:0] rsp_cycles;
  logic             core_ini, core_fin;

  logic             to_req_valid, to_req_ready, to_rsp_valid, to_rsp_ready, to_rsp_err;
  logic [W-1:0]     to_req_a, to_req_b, to_rsp_s, to_core_a, to_core_b;
  logic [CNT_W-1:0] to_rsp_cycles;
  logic             to_core_ini;

  always #5 clk = ~clk;

  nwd_ctrl #(.W(W), .CNT_W(CNT_W), .TIMEOUT(70000)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_err   (rsp_err),
    .rsp_cycles(rsp_cycles),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_ini  (core_ini),
    .core_s    (core_s),
    .core_fin  (core_fin)
  );

  nwd_ctrl #(.W(W), .CNT_W(CNT_W), .TIMEOUT(TO_SH)) u_dut_to (
    .clk       (clk),
    .rst       (rst),
    .req_valid (to_req_valid),
    .req_ready (to_req_ready),
    .req_a     (to_req_a),
    .req_b     (to_req_b),
    .rsp_valid (to_rsp_valid),
    .rsp_ready (to_rsp_ready),
    .rsp_s     (to_rsp_s),
    .rsp_err   (to_rsp_err),
    .rsp_cycles(to_rsp_cycles),
    .core_a    (to_core_a),
    .core_b    (to_core_b),
    .core_ini  (to_core_ini),
    .core_s    (16'hABCD),
    .core_fin  (1'b0)
  );

  // Behavioural core: loads on core_ini, then subtracts once per cycle.
  logic [W-1:0] cx = '0, cy = '0;
  always @(posedge clk) begin
    if (core_ini) begin
      cx <= core_a;
      cy <= core_b;
    end else if (cx > cy) begin
      cx <= cx - cy;
    end else if (cy > cx) begin
      cy <= cy - cx;
    end
  end
  assign core_fin = (cx == cy);
  assign core_s   = cx;

  int ini_cnt = 0;
  always @(posedge clk) if (core_ini === 1'b1) ini_cnt++;

  typedef struct packed {
    logic [W-1:0]     s;
    logic             err;
    logic [CNT_W-1:0] cyc;
    logic             byp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: GCD by repeated subtraction, counting the RUN cycle of each step.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] x, y;
    int n;
    e = '0;
    if (a == 0 && b == 0) begin
      e.err = 1'b1;
      e.byp = 1'b1;
    end else if (a == 0 || b == 0) begin
      e.s   = (a > b) ? a : b;
      e.byp = 1'b1;
    end else begin
      x = a;
      y = b;
      n = 1;
      while (x != y) begin
        if (x > y) x = x - y;
        else       y = y - x;
        n++;
      end
      e.s   = x;
      e.cyc = CNT_W'(n);
    end
    return e;
  endfunction

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int   n;
    int   ini0;
    n = 0;
    while (!req_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_wait", 32'(n < LIMIT), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    exp_q.push_back(model(a, b));
    ini0 = ini_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("core_a_latch", 32'(core_a), 32'(a));
    check_eq("core_b_latch", 32'(core_b), 32'(b));
    n = 0;
    while (!rsp_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_wait", 32'(n < LIMIT), 32'd1);
    e = exp_q[0];
    // One LOAD edge plus one edge per RUN cycle; bypass responds straight away.
    check_eq("latency", 32'(n), e.byp ? 32'd0 : 32'(e.cyc) + 32'd1);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_s", 32'(rsp_s), 32'(e.s));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check_eq("rsp_s", 32'(rsp_s), 32'(e.s));
    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
    check_eq("rsp_cycles", 32'(rsp_cycles), 32'(e.cyc));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
    check_eq("ini_pulses", 32'(ini_cnt - ini0), e.byp ? 32'd0 : 32'd1);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = 1'b0;
    to_req_valid = 1'b0;
    to_req_a     = '0;
    to_req_b     = '0;
    to_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_s", 32'(rsp_s), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
    check_eq("rst_core_ini", 32'(core_ini), 32'd0);
    check_eq("rst_core_ab", 32'({core_a, core_b}), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    do_req(16'd12, 16'd18, 0);
    do_req(16'd0, 16'd7, 0);
    do_req(16'd0, 16'd0, 0);
    do_req(16'd5, 16'd5, 0);
    do_req(16'd65535, 16'd65535, 0);
    do_req(16'd48, 16'd36, 10);
    do_req(16'd9, 16'd0, 2);
    do_req(16'd65535, 16'd1, 0);

    // Watchdog instance: core_fin never rises.
    to_req_valid = 1'b1;
    to_req_a     = 16'd4;
    to_req_b     = 16'd6;
    @(negedge clk);
    to_req_valid = 1'b0;
    n = 0;
    while (!to_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_latency", 32'(n), 32'(TO_SH) + 32'd1);
    check_eq("to_rsp_err", 32'(to_rsp_err), 32'd1);
    check_eq("to_rsp_s", 32'(to_rsp_s), 32'd0);
    check_eq("to_rsp_cycles", 32'(to_rsp_cycles), 32'(TO_SH));
    to_rsp_ready = 1'b1;
    @(negedge clk);
    to_rsp_ready = 1'b0;
    check_eq("to_post_ready", 32'(to_req_ready), 32'd1);

    // Reset while RUN is in progress drops the request.
    req_valid = 1'b1;
    req_a     = 16'd1000;
    req_b     = 16'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("midrun_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_core_ab", 32'({core_a, core_b}), 32'd0);
    check_eq("midrst_core_ini", 32'(core_ini), 32'd0);
    do_req(16'd9, 16'd6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
